// File: rtl/e203_exu_oitf_trk_pkg.sv
// Shared e203 sizing constants for the outstanding-instruction track FIFO.
package e203_exu_oitf_trk_pkg;

   localparam int unsigned E203_OITF_DEPTH  = 2;
   localparam int unsigned E203_ITAG_WIDTH  = 1;
   localparam int unsigned E203_RFIDX_WIDTH = 5;
   localparam int unsigned E203_PC_SIZE     = 32;

endpackage

// File: rtl/e203_exu_oitf_trk_ptr.sv
// Wrap-flag pointer: counts 0..DEPTH-1 and toggles r_flag each time it wraps.
module e203_oitf_ptr
   import e203_exu_oitf_trk_pkg::*;
#(
   parameter int unsigned DEPTH = E203_OITF_DEPTH,
   parameter int unsigned PTR_W = E203_ITAG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr,
   output logic             o_flag
);

   logic [PTR_W-1:0] r_ptr;
   logic             r_flag;
   logic             w_at_last;

   assign w_at_last = (r_ptr == PTR_W'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr  <= '0;
         r_flag <= 1'b0;
      end else if (i_inc) begin
         if (w_at_last) begin
            r_ptr  <= '0;
            r_flag <= ~r_flag;
         end else begin
            r_ptr  <= r_ptr + PTR_W'(1);
         end
      end
   end

   assign o_ptr  = r_ptr;
   assign o_flag = r_flag;

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding Instruction Track FIFO: holds long-pipe instructions from dispatch
// to write-back, supplying ITAGs, RAW/WAW hazard flags and an empty indication.
module e203_exu_oitf_trk
   import e203_exu_oitf_trk_pkg::*;
#(
   parameter int unsigned DEPTH   = E203_OITF_DEPTH,
   parameter int unsigned PTR_W   = E203_ITAG_WIDTH,
   parameter int unsigned RFIDX_W = E203_RFIDX_WIDTH,
   parameter int unsigned PC_W    = E203_PC_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dis_ena,
   output logic               dis_ready,
   output logic [PTR_W-1:0]   dis_ptr,
   input  logic               disp_rs1en,
   input  logic               disp_rs2en,
   input  logic               disp_rs3en,
   input  logic               disp_rs1fpu,
   input  logic               disp_rs2fpu,
   input  logic               disp_rs3fpu,
   input  logic               disp_rdfpu,
   input  logic               disp_rdwen,
   input  logic [RFIDX_W-1:0] disp_rs1idx,
   input  logic [RFIDX_W-1:0] disp_rs2idx,
   input  logic [RFIDX_W-1:0] disp_rs3idx,
   input  logic [RFIDX_W-1:0] disp_rdidx,
   input  logic [PC_W-1:0]    disp_pc,
   output logic               oitfrd_match_disprs1,
   output logic               oitfrd_match_disprs2,
   output logic               oitfrd_match_disprs3,
   output logic               oitfrd_match_disprd,
   input  logic               ret_ena,
   output logic [PTR_W-1:0]   ret_ptr,
   output logic [RFIDX_W-1:0] ret_rdidx,
   output logic               ret_rdwen,
   output logic               ret_rdfpu,
   output logic [PC_W-1:0]    ret_pc,
   output logic               oitf_empty
);

   logic [PTR_W-1:0]   w_alc_ptr;
   logic [PTR_W-1:0]   w_ret_ptr;
   logic               w_alc_flag;
   logic               w_ret_flag;
   logic               w_full;
   logic               w_empty;
   logic               w_alc;
   logic               w_ret;

   logic [DEPTH-1:0]   w_valid;
   logic [DEPTH-1:0]   w_rdwen;
   logic [DEPTH-1:0]   w_rdfpu;
   logic [RFIDX_W-1:0] w_rdidx [DEPTH];
   logic [PC_W-1:0]    w_pc    [DEPTH];
   logic [DEPTH-1:0]   w_hit_rs1;
   logic [DEPTH-1:0]   w_hit_rs2;
   logic [DEPTH-1:0]   w_hit_rs3;
   logic [DEPTH-1:0]   w_hit_rd;

   // Same pointer index: wrap flags distinguish empty from full.
   assign w_empty = (w_alc_ptr == w_ret_ptr) && (w_alc_flag == w_ret_flag);
   assign w_full  = (w_alc_ptr == w_ret_ptr) && (w_alc_flag != w_ret_flag);
   assign w_alc   = dis_ena & ~w_full;
   assign w_ret   = ret_ena & ~w_empty;

   e203_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_alc_ptr (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_alc),
      .o_ptr  (w_alc_ptr),
      .o_flag (w_alc_flag)
   );

   e203_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ret_ptr (
      .clk    (clk),
      .rst    (rst),
      .i_inc  (w_ret),
      .o_ptr  (w_ret_ptr),
      .o_flag (w_ret_flag)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic               r_valid;
      logic               r_rdwen;
      logic               r_rdfpu;
      logic [RFIDX_W-1:0] r_rdidx;
      logic [PC_W-1:0]    r_pc;
      logic               w_alc_here;
      logic               w_ret_here;

      assign w_alc_here = w_alc && (w_alc_ptr == PTR_W'(i));
      assign w_ret_here = w_ret && (w_ret_ptr == PTR_W'(i));

      // Allocation takes priority so a same-index alloc+ret leaves the entry live.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
         end else if (w_alc_here) begin
            r_valid <= 1'b1;
         end else if (w_ret_here) begin
            r_valid <= 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (w_alc_here) begin
            r_rdwen <= disp_rdwen;
            r_rdfpu <= disp_rdfpu;
            r_rdidx <= disp_rdidx;
            r_pc    <= disp_pc;
         end
      end

      assign w_valid[i] = r_valid;
      assign w_rdwen[i] = r_rdwen;
      assign w_rdfpu[i] = r_rdfpu;
      assign w_rdidx[i] = r_rdidx;
      assign w_pc[i]    = r_pc;

      assign w_hit_rs1[i] = r_valid & r_rdwen & disp_rs1en
                          & (r_rdidx == disp_rs1idx) & (r_rdfpu == disp_rs1fpu);
      assign w_hit_rs2[i] = r_valid & r_rdwen & disp_rs2en
                          & (r_rdidx == disp_rs2idx) & (r_rdfpu == disp_rs2fpu);
      assign w_hit_rs3[i] = r_valid & r_rdwen & disp_rs3en
                          & (r_rdidx == disp_rs3idx) & (r_rdfpu == disp_rs3fpu);
      assign w_hit_rd[i]  = r_valid & r_rdwen & disp_rdwen
                          & (r_rdidx == disp_rdidx)  & (r_rdfpu == disp_rdfpu);
   end

   assign dis_ready  = ~w_full;
   assign dis_ptr    = w_alc_ptr;
   assign oitf_empty = w_empty;

   assign oitfrd_match_disprs1 = |w_hit_rs1;
   assign oitfrd_match_disprs2 = |w_hit_rs2;
   assign oitfrd_match_disprs3 = |w_hit_rs3;
   assign oitfrd_match_disprd  = |w_hit_rd;

   assign ret_ptr   = w_ret_ptr;
   assign ret_rdidx = w_rdidx[w_ret_ptr];
   assign ret_rdwen = w_rdwen[w_ret_ptr];
   assign ret_rdfpu = w_rdfpu[w_ret_ptr];
   assign ret_pc    = w_pc[w_ret_ptr];

   // A lone request against a full/empty FIFO indicates an upstream handshake bug.
   a_no_alc_full: assert property (@(posedge clk) disable iff (rst)
      !(dis_ena && w_full && !ret_ena));
   a_no_ret_empty: assert property (@(posedge clk) disable iff (rst)
      !(ret_ena && w_empty && !dis_ena));

endmodule

// File: doc/e203_exu_oitf_trk.md
Name: e203_exu_oitf_trk

Overview:
Outstanding Instruction Track FIFO. It sits directly downstream of the EXU dispatch stage and consumes its OITF allocation and operand-index outputs. It records every long-pipe instruction, currently LSU/AGU, from dispatch until the long-pipe write-back retires it. It returns the entry tag used as the instruction ITAG, RAW/WAW match flags back to dispatch, and an empty flag used by CSR, fence and WFI gating.

Parameters:
DEPTH, 2, number of tracking entries; power of two, minimum 1.
PTR_W, 1, log2(DEPTH); entry tag width, equal to E203_ITAG_WIDTH.
RFIDX_W, 5, register index width, equal to E203_RFIDX_WIDTH.
PC_W, 32, PC width, equal to E203_PC_SIZE.

Ports:
clk  in  1  core clock
rst  in  1  reset
dis_ena  in  1  allocate an entry this cycle
dis_ready  out  1  at least one free entry (~full)
dis_ptr  out  PTR_W  tag of the entry the next allocation takes
disp_rs1en / disp_rs2en / disp_rs3en  in  1 each  dispatching instruction reads rs1 / rs2 / rs3
disp_rs1fpu / disp_rs2fpu / disp_rs3fpu / disp_rdfpu  in  1 each  operand is in the FP register file
disp_rdwen  in  1  dispatching instruction writes rd
disp_rs1idx / disp_rs2idx / disp_rs3idx / disp_rdidx  in  RFIDX_W each  register indexes
disp_pc  in  PC_W  PC of the dispatching instruction
oitfrd_match_disprs1 / rs2 / rs3 / rd  out  1 each  hazard match against a valid entry
ret_ena  in  1  retire the oldest entry
ret_ptr  out  PTR_W  tag of the oldest entry
ret_rdidx  out  RFIDX_W  rd of the oldest entry
ret_rdwen  out  1  oldest entry writes rd
ret_rdfpu  out  1  oldest entry rd is in the FP register file
ret_pc  out  PC_W  PC of the oldest entry
oitf_empty  out  1  no valid entries

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- State:
  - alc_ptr and ret_ptr, each PTR_W bits plus a wrap flag.
  - Per-entry valid bit, rdwen, rdfpu, rdidx and pc.
- Reset (asynchronous, active-high):
  - Pointers and wrap flags cleared; all valid bits cleared.
  - Therefore oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, all match outputs=0.
  - Payload registers need no reset; ret_* outputs are don't-care while empty.
- Full/empty:
  - empty = pointers equal and wrap flags equal; full = pointers equal and wrap flags differ.
  - DEPTH=1 uses the same rule.
- Allocation:
  - On dis_ena & ~full: entry[alc_ptr] is written with valid=1, rdwen, rdfpu, rdidx and pc from the disp_* inputs.
  - alc_ptr increments; on wrap it returns to 0 and toggles its wrap flag.
  - dis_ena while full is ignored (no state change) and is flagged by an assertion.
- Retirement:
  - On ret_enaring & ~empty: entry[ret_ptr].valid is cleared and ret_ptr increments with the same wrap rule.
  - ret_ena while empty is ignored and is flagged by an assertion.
- Simultaneous allocation and retirement in one cycle:
  - Both occur; occupancy is unchanged.
  - When full, dis_ready=0, so only the retirement proceeds.
  - When empty, only the allocation proceeds; a same-cycle ret_ena is ignored and not bypassed.
  - With DEPTH=1, same-cycle alloc+ret on the same index: retire clears valid, allocate sets it; allocate wins.
- dis_ptr = alc_ptr, combinational from registers.
- ret_* outputs read entry[ret_ptr] combinationally from registers; latency is zero cycles after state is committed.
- Match logic is purely combinational from the registers and disp_* inputs, with no same-cycle bypass of an entry being allocated.
  - oitfrd_match_disprs1 = OR over i of (valid[i] & rdwen[i] & disp_rs1en & rdidx[i]==disp_rs1idx & rdfpu[i]==disp_rs1fpu).
  - rs2 and rs3 follow the same form with their own enable, index and fpu inputs.
  - rd uses disp_rdwen, disp_rdidx and disp_rdfpu.
  - No masking for x0; the upstream rs*en already excludes x0 reads.
- oitf_empty is registered-derived (pointer compare), never dependent on same-cycle dis_ena or ret_ena.
- Retirement is strictly in order; tags are reused only after retirement.

Decomposition:
- Shared e203 defines supply E203_ITAG_WIDTH, E203_RFIDX_WIDTH, E203_PC_SIZE and E203_OITF_DEPTH; the parameters default to these.
- One natural sub-module: e203_oitf_ptr, a wrap-flag pointer counter with increment enable, reset to 0. It is instantiated twice (allocation and retirement).
- Entry storage and match comparators are generated in a for-generate loop over DEPTH.

Test Plan:
- Reset mid-operation: fill 2 entries, assert rst for 1 cycle → oitf_empty=1, dis_ready=1, dis_ptr=0, all matches 0 immediately (asynchronous).
- Fill to full, DEPTH=2: allocate rd=x5 (pc 0x80), then rd=x7 (pc 0x84) → dis_ptr 0→1→0, dis_ready=0, oitf_empty=0, ret_rdidx=5, ret_pc=0x80.
- Hazard match: entry rd=x5, rdwen=1; disp rs1en=1 rs1idx=5 → match_disprs1=1. Same with rs1fpu=1 → 0. disp_rdwen=1 rdidx=5 → match_disprd=1. After retire → all 0.
- Simultaneous alloc+ret at occupancy 1 over 6 cycles → occupancy stays 1, tags wrap 0,1,0 with wrap flags toggling, ret_rdidx tracks in-order rd values.
- Full with dis_ena=1 and ret_ena=1 → only retire takes effect, dis_ready=1 next cycle, no overwrite of the younger entry (its ret_pc=0x84 next).
- Empty with ret_ena=1 and dis_ena=1 (rd=x9) → entry allocated, oitf_empty=0 next cycle, ret_rdidx=9, pointers consistent.
